// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/DM arbiter onto one single-ported memory, DM priority with IF anti-starvation.
// Optional ARB_PERF_EN adds per-port wait-cycle counters.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ack_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              stall_o
`ifdef ARB_PERF_EN
    ,
    output logic [31:0]       if_wait_cnt_o,
    output logic [31:0]       dm_wait_cnt_o
`endif
);

    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, RESP} state_t;

    state_t          state_q, state_d;
    logic            owner_if_q;
    logic [SW-1:0]   starve_q;
    logic            if_win, grant_if, grant_dm, busy;

    // IF takes the slot when alone or once DM has beaten it STARVE_MAX times in a row
    assign if_win = if_req_i && (!dm_req_i || (starve_q == STARVE_LIM));
    assign busy   = (state_q == BUSY_IF) || (state_q == BUSY_DM);

    always_comb begin
        state_d  = state_q;
        grant_if = 1'b0;
        grant_dm = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i && (if_req_i || dm_req_i)) begin
                    if (if_win) begin
                        state_d  = BUSY_IF;
                        grant_if = 1'b1;
                    end else begin
                        state_d  = BUSY_DM;
                        grant_dm = 1'b1;
                    end
                end
            end
            BUSY_IF, BUSY_DM: begin
                if (mem_ack_i) state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            owner_if_q  <= 1'b0;
            starve_q    <= '0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            if_rdata_o  <= '0;
            dm_rdata_o  <= '0;
        end else begin
            state_q <= state_d;
            if (grant_if || grant_dm) begin
                owner_if_q  <= grant_if;
                mem_we_o    <= grant_dm && dm_we_i;
                mem_addr_o  <= grant_if ? if_addr_i : dm_addr_i;
                mem_wdata_o <= grant_if ? '0 : dm_wdata_i;
            end
            if (busy && mem_ack_i) begin
                if (owner_if_q)     if_rdata_o <= mem_rdata_i;
                else if (!mem_we_o) dm_rdata_o <= mem_rdata_i;
            end
            if (grant_if)
                starve_q <= '0;
            else if (grant_dm && if_req_i && (starve_q != STARVE_LIM))
                starve_q <= starve_q + SW'(1);
            else if ((state_q == IDLE) && !if_req_i)
                starve_q <= '0;
        end
    end

    assign mem_req_o = busy;
    assign if_ack_o  = (state_q == RESP) && owner_if_q;
    assign dm_ack_o  = (state_q == RESP) && !owner_if_q;
    assign stall_o   = (if_req_i && !if_ack_o) || (dm_req_i && !dm_ack_o);

`ifdef ARB_PERF_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            if_wait_cnt_o <= '0;
            dm_wait_cnt_o <= '0;
        end else begin
            if (if_req_i && !if_ack_o && (if_wait_cnt_o != '1))
                if_wait_cnt_o <= if_wait_cnt_o + 32'd1;
            if (dm_req_i && !dm_ack_o && (dm_wait_cnt_o != '1))
                dm_wait_cnt_o <= dm_wait_cnt_o + 32'd1;
        end
    end
`endif

endmodule
